exe_stage: RTL and testbench
============================

// Module: exe_stage
// PURPOSE
//  Execute stage of the 5-stage ARM pipeline: consumes the control word produced by ID decode
//  (exe_cmd, mem_read, mem_write, wb_en, branch, s_en) plus operands from the ID/EX register.
//  Builds Val2, runs the ALU, owns the NZCV status register, computes branch target, and
//  registers everything into the EX/MEM boundary. Status feeds back to ID condition check.
// PARAMETERS
//  DATA_W  32  datapath width (only 32 supported)
//  REG_W   4   destination register index width
// PORTS
//  clk            in   1       rising-edge clock
//  rst            in   1       async, active-high reset
//  in_valid       in   1       ID/EX slot holds a live instruction
//  exe_cmd        in   4       ALU op: 0001 MOV,1001 MVN,0010 ADD,0011 ADC,0100 SUB,0101 SBC,0110 AND,0111 ORR,1000 EOR,0000 none
//  mem_read/mem_write/wb_en/branch  in 1 each  decoded control bits
//  s_en           in   1       update NZCV with this result
//  imm            in   1       I bit: shift_operand is rotated immediate
//  shift_operand  in   12      operand-2 field
//  signed_imm24   in   24      branch offset
//  pc             in   32      PC+4 of this instruction
//  val_rn, val_rm in   32      register operands
//  dest           in   REG_W   destination register
//  freeze         in   1       hold stage (hazard stall)
//  flush          in   1       kill incoming instruction
//  alu_res_o      out  32      ALU result / memory address
//  st_val_o       out  32      store data (val_rm)
//  dest_o         out  REG_W
//  wb_en_o, mem_read_o, mem_write_o, valid_o  out 1 each
//  branch_taken_o out  1       registered branch request
//  branch_addr_o  out  32      pc + sign_ext(imm24)<<2
//  status_o       out  4       NZCV = {N,Z,C,V}, current status register
// BEHAVIOUR
//  - Reset: all outputs and status register 0.
//  - Latency 1: inputs sampled at edge k appear on *_o after edge k; status_o updates same edge.
//  - Edge priority: flush > freeze > load. flush: valid_o, wb_en_o, mem_*_o, branch_taken_o <= 0,
//    data outputs don't-care (hold), NZCV not written. freeze: all regs hold, input not consumed.
//  - in_valid=0 loads a bubble (same as flush). Enables out are gated by in_valid.
//  - Val2: mem_read|mem_write -> zero_ext(shift_operand[11:0]); else imm=1 -> {24'b0,[7:0]}
//    ROR 2*[11:8]; else val_rm shifted by [11:7] using type [6:5] (00 LSL,01 LSR,10 ASR,11 ROR).
//    Shift amount 0 passes val_rm unchanged (no RRX/#32 forms).
//  - ALU uses Cin = status C (registered). SUB: rn-val2, C = NOT borrow. SBC: rn-val2-!C.
//    ADD/ADC: C = carry out bit 32. V per signed overflow of add/sub.
//    MOV/MVN/AND/ORR/EOR: N,Z from result; C,V keep current value. exe_cmd 0000: result 0.
//  - NZCV written only when in_valid & s_en & !flush & !freeze. CMP/TST arrive with wb_en=0, s_en=1.
//  - Back-to-back ADDS -> ADC: second sees first's C (status written at the edge between them).
//  - branch_taken_o = in_valid & branch; branch_addr_o 32-bit wrap-around add, no overflow flag.
//  - rst asserted mid-operation clears everything immediately; first edge after release loads normally.
// STRUCTURE
//  - arm_pkg: exe_cmd localparams, shift-type encodings, NZCV bit indices.
//  - Sub-module val2_gen (combinational Val2 builder); ALU, status reg, EX/MEM reg inline.
// TESTING
//  1. ADDS rn=0x7FFFFFFF, imm 1 -> alu_res_o=0x80000000, NZCV=1001 one edge later.
//  2. SUBS rn=5, val2=5 then SBC rn=0, val2=0 -> first NZCV=0110; SBC result 0 (C=1 so no borrow).
//  3. imm=1, shift_operand=0x4FF (rot 4, imm8 0xFF) MOV -> alu_res_o=0xFF000000; LSL rm=1 by 31 -> 0x80000000.
//  4. LDR rn=0x100, shift_operand=0x004 -> alu_res_o=0x104, mem_read_o=1, NZCV unchanged even with s_en=1.
//  5. B pc=0x20, imm24=0xFFFFFE -> branch_addr_o=0x18, branch_taken_o=1; same with flush=1 -> taken 0.
//  6. freeze held 3 cycles with new inputs -> outputs/NZCV stable; rst pulse mid-freeze -> all 0.

Source files
------------

// File: rtl/arm_pkg.sv
// Shared encodings for the ARM execute stage: ALU commands, shift types and NZCV bit positions.
package arm_pkg;

  localparam logic [3:0] CmdNone = 4'b0000;
  localparam logic [3:0] CmdMov  = 4'b0001;
  localparam logic [3:0] CmdAdd  = 4'b0010;
  localparam logic [3:0] CmdAdc  = 4'b0011;
  localparam logic [3:0] CmdSub  = 4'b0100;
  localparam logic [3:0] CmdSbc  = 4'b0101;
  localparam logic [3:0] CmdAnd  = 4'b0110;
  localparam logic [3:0] CmdOrr  = 4'b0111;
  localparam logic [3:0] CmdEor  = 4'b1000;
  localparam logic [3:0] CmdMvn  = 4'b1001;

  localparam logic [1:0] ShLsl = 2'b00;
  localparam logic [1:0] ShLsr = 2'b01;
  localparam logic [1:0] ShAsr = 2'b10;
  localparam logic [1:0] ShRor = 2'b11;

  localparam int unsigned FlagN = 3;
  localparam int unsigned FlagZ = 2;
  localparam int unsigned FlagC = 1;
  localparam int unsigned FlagV = 0;

endpackage

// File: rtl/val2_gen.sv
// Operand-2 builder: memory offset, rotated immediate, or shifted register.
module val2_gen
  import arm_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] val_rm_i,
  input  logic [11:0]       shift_operand_i,
  input  logic              imm_i,
  input  logic              mem_op_i,
  output logic [DATA_W-1:0] val2_o
);

  logic [DATA_W-1:0]   imm_ext;
  logic [2*DATA_W-1:0] dbl;
  logic [4:0]          amt;

  always_comb begin
    imm_ext = {{(DATA_W-8){1'b0}}, shift_operand_i[7:0]};
    amt     = shift_operand_i[11:7];
    dbl     = '0;
    val2_o  = val_rm_i;
    if (mem_op_i) begin
      val2_o = {{(DATA_W-12){1'b0}}, shift_operand_i};
    end else if (imm_i) begin
      // Rotate by doubling the word and shifting, so a rotation of 0 needs no special case.
      dbl    = {imm_ext, imm_ext} >> {shift_operand_i[11:8], 1'b0};
      val2_o = dbl[DATA_W-1:0];
    end else begin
      case (shift_operand_i[6:5])
        ShLsl: val2_o = val_rm_i << amt;
        ShLsr: val2_o = val_rm_i >> amt;
        ShAsr: val2_o = $signed(val_rm_i) >>> amt;
        default: begin
          dbl    = {val_rm_i, val_rm_i} >> amt;
          val2_o = dbl[DATA_W-1:0];
        end
      endcase
    end
  end

endmodule

// File: rtl/exe_stage.sv
// ARM execute stage: Val2, ALU, NZCV status register, branch target and the EX/MEM register.
module exe_stage
  import arm_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [3:0]        exe_cmd,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              wb_en,
  input  logic              branch,
  input  logic              s_en,
  input  logic              imm,
  input  logic [11:0]       shift_operand,
  input  logic [23:0]       signed_imm24,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] val_rn,
  input  logic [DATA_W-1:0] val_rm,
  input  logic [REG_W-1:0]  dest,
  input  logic              freeze,
  input  logic              flush,
  output logic [DATA_W-1:0] alu_res_o,
  output logic [DATA_W-1:0] st_val_o,
  output logic [REG_W-1:0]  dest_o,
  output logic              wb_en_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic              valid_o,
  output logic              branch_taken_o,
  output logic [DATA_W-1:0] branch_addr_o,
  output logic [3:0]        status_o
);

  localparam int unsigned Msb = DATA_W - 1;

  logic              mem_op;
  logic [DATA_W-1:0] val2, opb, alu_res;
  logic [DATA_W:0]   sum;
  logic              cin, c_new, v_new;
  logic [3:0]        nzcv_new;

  logic [DATA_W-1:0] alu_q, alu_d, st_q, st_d, baddr_q, baddr_d;
  logic [REG_W-1:0]  dest_q, dest_d;
  logic              wb_q, wb_d, mr_q, mr_d, mw_q, mw_d, valid_q, valid_d, bt_q, bt_d;
  logic [3:0]        nzcv_q, nzcv_d;

  assign mem_op = mem_read | mem_write;

  val2_gen #(
    .DATA_W(DATA_W)
  ) u_val2 (
    .val_rm_i       (val_rm),
    .shift_operand_i(shift_operand),
    .imm_i          (imm),
    .mem_op_i       (mem_op),
    .val2_o         (val2)
  );

  always_comb begin
    cin     = nzcv_q[FlagC];
    c_new   = cin;
    v_new   = nzcv_q[FlagV];
    opb     = val2;
    sum     = '0;
    alu_res = '0;
    case (exe_cmd)
      CmdMov: alu_res = val2;
      CmdMvn: alu_res = ~val2;
      CmdAnd: alu_res = val_rn & val2;
      CmdOrr: alu_res = val_rn | val2;
      CmdEor: alu_res = val_rn ^ val2;
      CmdAdd, CmdAdc: begin
        sum     = {1'b0, val_rn} + {1'b0, val2}
                + {{DATA_W{1'b0}}, cin & (exe_cmd == CmdAdc)};
        alu_res = sum[Msb:0];
        c_new   = sum[DATA_W];
        v_new   = (val_rn[Msb] == opb[Msb]) && (alu_res[Msb] != val_rn[Msb]);
      end
      CmdSub, CmdSbc: begin
        // Subtract as rn + ~val2 + carry; the carry out is then NOT borrow.
        opb     = ~val2;
        sum     = {1'b0, val_rn} + {1'b0, opb}
                + {{DATA_W{1'b0}}, (exe_cmd == CmdSub) | cin};
        alu_res = sum[Msb:0];
        c_new   = sum[DATA_W];
        v_new   = (val_rn[Msb] == opb[Msb]) && (alu_res[Msb] != val_rn[Msb]);
      end
      default: alu_res = '0;
    endcase
    nzcv_new = {alu_res[Msb], alu_res == '0, c_new, v_new};
  end

  always_comb begin
    alu_d   = alu_q;
    st_d    = st_q;
    baddr_d = baddr_q;
    dest_d  = dest_q;
    wb_d    = wb_q;
    mr_d    = mr_q;
    mw_d    = mw_q;
    valid_d = valid_q;
    bt_d    = bt_q;
    nzcv_d  = nzcv_q;
    if (flush || (!freeze && !in_valid)) begin
      wb_d    = 1'b0;
      mr_d    = 1'b0;
      mw_d    = 1'b0;
      valid_d = 1'b0;
      bt_d    = 1'b0;
    end else if (!freeze) begin
      alu_d   = alu_res;
      st_d    = val_rm;
      baddr_d = pc + {{(DATA_W-26){signed_imm24[23]}}, signed_imm24, 2'b00};
      dest_d  = dest;
      wb_d    = wb_en;
      mr_d    = mem_read;
      mw_d    = mem_write;
      valid_d = 1'b1;
      bt_d    = branch;
      // Address calculation for loads/stores must not disturb the flags.
      if (s_en && !mem_op) nzcv_d = nzcv_new;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_q   <= '0;
      st_q    <= '0;
      baddr_q <= '0;
      dest_q  <= '0;
      wb_q    <= 1'b0;
      mr_q    <= 1'b0;
      mw_q    <= 1'b0;
      valid_q <= 1'b0;
      bt_q    <= 1'b0;
      nzcv_q  <= '0;
    end else begin
      alu_q   <= alu_d;
      st_q    <= st_d;
      baddr_q <= baddr_d;
      dest_q  <= dest_d;
      wb_q    <= wb_d;
      mr_q    <= mr_d;
      mw_q    <= mw_d;
      valid_q <= valid_d;
      bt_q    <= bt_d;
      nzcv_q  <= nzcv_d;
    end
  end

  assign alu_res_o      = alu_q;
  assign st_val_o       = st_q;
  assign dest_o         = dest_q;
  assign wb_en_o        = wb_q;
  assign mem_read_o     = mr_q;
  assign mem_write_o    = mw_q;
  assign valid_o        = valid_q;
  assign branch_taken_o = bt_q;
  assign branch_addr_o  = baddr_q;
  assign status_o       = nzcv_q;

endmodule

// File: tb/tb_exe_stage.sv
// Scoreboard bench for exe_stage: a reference model predicts every registered output each cycle.
module tb_exe_stage;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] st;
    logic [3:0]  dest;
    logic        wb;
    logic        mr;
    logic        mw;
    logic        valid;
    logic        bt;
    logic [31:0] baddr;
    logic [3:0]  nzcv;
  } out_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, mem_read, mem_write, wb_en, branch, s_en, imm, freeze, flush;
  logic [3:0]  exe_cmd, dest;
  logic [11:0] shift_operand;
  logic [23:0] signed_imm24;
  logic [31:0] pc, val_rn, val_rm;

  logic [31:0] alu_res_o, st_val_o, branch_addr_o;
  logic [3:0]  dest_o, status_o;
  logic        wb_en_o, mem_read_o, mem_write_o, valid_o, branch_taken_o;

  int   total = 0;
  int   bad = 0;
  out_t m;
  out_t exp_q[$];

  always #5 clk = ~clk;

  exe_stage #(
    .DATA_W(32),
    .REG_W (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .exe_cmd       (exe_cmd),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .wb_en         (wb_en),
    .branch        (branch),
    .s_en          (s_en),
    .imm           (imm),
    .shift_operand (shift_operand),
    .signed_imm24  (signed_imm24),
    .pc            (pc),
    .val_rn        (val_rn),
    .val_rm        (val_rm),
    .dest          (dest),
    .freeze        (freeze),
    .flush         (flush),
    .alu_res_o     (alu_res_o),
    .st_val_o      (st_val_o),
    .dest_o        (dest_o),
    .wb_en_o       (wb_en_o),
    .mem_read_o    (mem_read_o),
    .mem_write_o   (mem_write_o),
    .valid_o       (valid_o),
    .branch_taken_o(branch_taken_o),
    .branch_addr_o (branch_addr_o),
    .status_o      (status_o)
  );

  function automatic logic [31:0] ror32(logic [31:0] x, int r);
    if (r == 0) return x;
    return (x >> r) | (x << (32 - r));
  endfunction

  function automatic logic [31:0] ref_val2(logic [31:0] rm, logic [11:0] so, logic im, logic mem);
    int amt;
    amt = int'(so[11:7]);
    if (mem) return {20'd0, so};
    if (im) return ror32({24'd0, so[7:0]}, 2 * int'(so[11:8]));
    case (so[6:5])
      2'd0:    return rm << amt;
      2'd1:    return rm >> amt;
      2'd2:    return $signed(rm) >>> amt;
      default: return ror32(rm, amt);
    endcase
  endfunction

  // Returns {N,Z,C,V, result}.
  function automatic logic [35:0] ref_alu(logic [3:0] cmd, logic [31:0] a, logic [31:0] b,
                                          logic [3:0] f);
    longint ua, ub, sa, sb, u, s, bi;
    logic c, v;
    logic [31:0] r;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    c  = f[1];
    v  = f[0];
    bi = f[1] ? 64'sd0 : 64'sd1;
    s  = 0;
    u  = 0;
    r  = 32'd0;
    case (cmd)
      4'b0001: r = b;
      4'b1001: r = ~b;
      4'b0110: r = a & b;
      4'b0111: r = a | b;
      4'b1000: r = a ^ b;
      4'b0010, 4'b0011: begin
        u = ua + ub + ((cmd == 4'b0011) ? longint'(f[1]) : 0);
        s = sa + sb + ((cmd == 4'b0011) ? longint'(f[1]) : 0);
        r = u[31:0];
        c = u > 64'sd4294967295;
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'b0100: begin
        r = a - b;
        c = ua >= ub;
        s = sa - sb;
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'b0101: begin
        r = a - b - 32'(bi);
        c = ua >= ub + bi;
        s = sa - sb - bi;
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      default: r = 32'd0;
    endcase
    return {r[31], r == 32'd0, c, v, r};
  endfunction

  // Predict the state after the coming edge, queue it, and advance one cycle.
  task automatic apply();
    out_t n;
    logic [35:0] a;
    longint off;
    n = m;
    if (rst) begin
      n = '0;
    end else if (flush || (!freeze && !in_valid)) begin
      n.wb = 0; n.mr = 0; n.mw = 0; n.valid = 0; n.bt = 0;
    end else if (!freeze) begin
      a = ref_alu(exe_cmd, val_rn,
                  ref_val2(val_rm, shift_operand, imm, mem_read | mem_write), m.nzcv);
      off = longint'($signed(signed_imm24));
      n.alu = a[31:0];
      n.st = val_rm;
      n.dest = dest;
      n.wb = wb_en;
      n.mr = mem_read;
      n.mw = mem_write;
      n.valid = 1;
      n.bt = branch;
      n.baddr = pc + 32'(off * 4);
      if (s_en && !(mem_read || mem_write)) n.nzcv = a[35:32];
    end
    m = n;
    exp_q.push_back(n);
    @(negedge clk);
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_op(logic [3:0] cmd, logic [31:0] rn, logic [31:0] rm, logic [11:0] so,
                        logic im, logic s);
    in_valid = 1; flush = 0; freeze = 0; mem_read = 0; mem_write = 0; wb_en = 1; branch = 0;
    exe_cmd = cmd; val_rn = rn; val_rm = rm; shift_operand = so; imm = im; s_en = s;
    dest = 4'(rn[3:0] ^ rm[3:0]); pc = 32'h1000; signed_imm24 = 24'd0;
  endtask

  initial begin : monitor
    out_t act, e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        act = '{alu: alu_res_o, st: st_val_o, dest: dest_o, wb: wb_en_o, mr: mem_read_o,
                mw: mem_write_o, valid: valid_o, bt: branch_taken_o, baddr: branch_addr_o,
                nzcv: status_o};
        total++;
        if (act !== e) begin
          bad++;
          $display("FAIL scoreboard @%0t: got %h expected %h", $time, act, e);
        end
      end
    end
  end

  initial begin : driver
    logic [31:0] edge_vals [5];
    logic [31:0] held;
    edge_vals[0] = 32'h0; edge_vals[1] = 32'h1; edge_vals[2] = 32'h7FFFFFFF;
    edge_vals[3] = 32'h80000000; edge_vals[4] = 32'hFFFFFFFF;
    rst = 1;
    m = '0;
    set_op(4'b0000, 32'd0, 32'd0, 12'd0, 1'b0, 1'b0);
    in_valid = 0;
    repeat (2) @(negedge clk);
    chk("reset_alu", alu_res_o, 32'd0);
    chk("reset_status", {28'd0, status_o}, 32'd0);
    chk("reset_valid", {31'd0, valid_o}, 32'd0);
    rst = 0;

    // ADDS overflow into the sign bit
    set_op(4'b0010, 32'h7FFFFFFF, 32'd0, 12'h001, 1'b1, 1'b1);
    apply();
    chk("adds_res", alu_res_o, 32'h80000000);
    chk("adds_nzcv", {28'd0, status_o}, 32'h9);

    // SUBS equal operands, then SBC with C=1 (no borrow)
    set_op(4'b0100, 32'd5, 32'd5, 12'd0, 1'b0, 1'b1);
    apply();
    chk("subs_nzcv", {28'd0, status_o}, 32'h6);
    set_op(4'b0101, 32'd0, 32'd0, 12'h000, 1'b1, 1'b0);
    apply();
    chk("sbc_res", alu_res_o, 32'd0);

    // Rotated immediate and LSL by 31
    set_op(4'b0001, 32'd0, 32'd0, 12'h4FF, 1'b1, 1'b0);
    apply();
    chk("mov_rot_imm", alu_res_o, 32'hFF000000);
    set_op(4'b0001, 32'd0, 32'd1, 12'hF80, 1'b0, 1'b0);
    apply();
    chk("mov_lsl31", alu_res_o, 32'h80000000);

    // LDR address with s_en set must leave flags alone
    set_op(4'b0010, 32'h100, 32'd0, 12'h004, 1'b0, 1'b1);
    mem_read = 1;
    apply();
    chk("ldr_addr", alu_res_o, 32'h104);
    chk("ldr_mem_read", {31'd0, mem_read_o}, 32'd1);
    chk("ldr_nzcv", {28'd0, status_o}, 32'h6);

    // Branch backwards, then the same under flush
    set_op(4'b0000, 32'd0, 32'd0, 12'd0, 1'b0, 1'b0);
    wb_en = 0; branch = 1; pc = 32'h20; signed_imm24 = 24'hFFFFFE;
    apply();
    chk("b_addr", branch_addr_o, 32'h18);
    chk("b_taken", {31'd0, branch_taken_o}, 32'd1);
    flush = 1;
    apply();
    chk("b_flush_taken", {31'd0, branch_taken_o}, 32'd0);

    // Freeze for three cycles with changing inputs, then reset mid-freeze
    set_op(4'b0010, 32'd40, 32'd0, 12'h002, 1'b1, 1'b1);
    apply();
    held = alu_res_o;
    chk("pre_freeze", held, 32'd42);
    for (int i = 0; i < 3; i++) begin
      set_op(4'b0100, 32'($urandom), 32'($urandom), 12'($urandom), 1'b0, 1'b1);
      freeze = 1;
      apply();
      chk("freeze_hold", alu_res_o, 32'd42);
    end
    rst = 1;
    #1;
    chk("rst_async_alu", alu_res_o, 32'd0);
    chk("rst_async_valid", {31'd0, valid_o}, 32'd0);
    apply();
    rst = 0;

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      int r;
      in_valid = $urandom_range(0, 7) != 0;
      flush = $urandom_range(0, 9) == 0;
      freeze = $urandom_range(0, 5) == 0;
      exe_cmd = 4'($urandom_range(0, 10));
      r = $urandom_range(0, 7);
      mem_read = (r == 0);
      mem_write = (r == 1);
      wb_en = 1'($urandom);
      branch = $urandom_range(0, 5) == 0;
      s_en = 1'($urandom);
      imm = 1'($urandom);
      shift_operand = 12'($urandom);
      signed_imm24 = 24'($urandom);
      pc = 32'($urandom);
      val_rn = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 4)] : 32'($urandom);
      val_rm = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 4)] : 32'($urandom);
      dest = 4'($urandom);
      apply();
    end

    repeat (3) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
